// File: rtl/pulse_generator_multi.sv
// Multi-channel gate synchroniser with edge pulses, a stretched pulse and re-trigger holdoff per channel.
// Latency: gate->pulse_up/dn SYNC_STAGES cycles, pulse_o one cycle later; no backpressure, overruns flagged sticky.
module pulse_generator_multi #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 4,
  parameter int HOLDOFF     = 0
) (
  input  logic               clk_o,
  input  logic               resetn_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic [NCH-1:0]     gate_i,
  input  logic [2*NCH-1:0]   mode_i,
  output logic [NCH-1:0]     pulse_up,
  output logic [NCH-1:0]     pulse_dn,
  output logic [NCH-1:0]     pulse_o,
  output logic [NCH-1:0]     busy_o,
  output logic [NCH-1:0]     ovr_o
);

  localparam int CMAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(SYNC_STAGES + 2);

  localparam logic [CW-1:0] LEN_M1   = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HOLD_M1  = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;
  localparam logic [IW-1:0] INIT_END = IW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  // Edges are masked until the sync chain has flushed the levels present at reset.
  logic [IW-1:0] init_cnt;
  logic          init_done;

  always_ff @(posedge clk_o or negedge resetn_i) begin
    if (!resetn_i) begin
      init_cnt <= '0;
    end else if (init_cnt != INIT_END) begin
      init_cnt <= init_cnt + IW'(1);
    end
  end

  assign init_done = (init_cnt == INIT_END);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   edge_q;
    logic                   trig;
    logic                   ovr_set;
    logic                   ovr_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_o or negedge resetn_i) begin
      if (!resetn_i) begin
        sync_q <= '0;
        edge_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], gate_i[c]};
        edge_q <= sync;
      end
    end

    assign pulse_up[c] = sync & ~edge_q & init_done;
    assign pulse_dn[c] = ~sync & edge_q & init_done;
    assign trig = ((mode_i[2*c] & pulse_up[c]) | (mode_i[2*c+1] & pulse_dn[c])) & enable_i;

    always_ff @(posedge clk_o or negedge resetn_i) begin
      if (!resetn_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        ovr_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ovr_q   <= (ovr_q & ~clear_i) | ovr_set;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovr_set = 1'b0;
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_d = ACTIVE;
            cnt_d   = LEN_M1;
          end
        end
        ACTIVE: begin
          ovr_set = trig;
          if (cnt_q == '0) begin
            if (HOLDOFF > 0) begin
              state_d = HOLD;
              cnt_d   = HOLD_M1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        HOLD: begin
          // A trigger in the final holdoff cycle still counts as an overrun.
          ovr_set = trig;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign pulse_o[c] = (state_q == ACTIVE);
    assign busy_o[c]  = (state_q != IDLE);
    assign ovr_o[c]   = ovr_q;
  end

endmodule

// File: tb/tb_pulse_generator_multi.sv
// Directed bench for pulse_generator_multi: one row per clock, inputs applied then outputs checked 1ns after the edge.
module tb_pulse_generator_multi;

  logic       clk_o = 1'b0;
  logic       resetn_i;
  logic       enable_i;
  logic       clear_i;
  logic [3:0] gate_i;
  logic [7:0] mode_i;
  logic [3:0] pulse_up, pulse_dn, pulse_o, busy_o, ovr_o;

  int n_tests = 0;
  int n_fail  = 0;

  pulse_generator_multi #(
    .NCH(4), .SYNC_STAGES(2), .PULSE_LEN(3), .HOLDOFF(2)
  ) dut (
    .clk_o    (clk_o),
    .resetn_i (resetn_i),
    .enable_i (enable_i),
    .clear_i  (clear_i),
    .gate_i   (gate_i),
    .mode_i   (mode_i),
    .pulse_up (pulse_up),
    .pulse_dn (pulse_dn),
    .pulse_o  (pulse_o),
    .busy_o   (busy_o),
    .ovr_o    (ovr_o)
  );

  always #5 clk_o = ~clk_o;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs of a row are sampled at the row's clock edge; expected values are the outputs after it.
  task automatic cyc(input string tag, input logic en, input logic clr, input logic [3:0] g,
                     input logic [3:0] up, input logic [3:0] dn, input logic [3:0] po,
                     input logic [3:0] bz, input logic [3:0] ov);
    enable_i = en;
    clear_i  = clr;
    gate_i   = g;
    @(posedge clk_o);
    #1;
    check({tag, "/up"},   pulse_up, up);
    check({tag, "/dn"},   pulse_dn, dn);
    check({tag, "/po"},   pulse_o,  po);
    check({tag, "/busy"}, busy_o,   bz);
    check({tag, "/ovr"},  ovr_o,    ov);
  endtask

  initial begin
    resetn_i = 1'b0;
    enable_i = 1'b1;
    clear_i  = 1'b0;
    gate_i   = 4'b0001;
    mode_i   = 8'b01010101;

    // Reset state, gate 0 already high
    cyc("rst", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("rst", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    resetn_i = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc("init", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Single rise on ch1, mode rise-only; fall afterwards is ignored by the FSM
    cyc("t2k0", 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t2k1", 1, 0, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t2k2", 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    cyc("t2k3", 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    cyc("t2k4", 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    cyc("t2k5", 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    cyc("t2k6", 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    cyc("t2k7", 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t2k8", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t2k9", 1, 0, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    cyc("t2ka", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch2 both-edge mode, 2-clk gate: fall arrives mid-pulse -> overrun, then clear
    mode_i = 8'b01110101;
    cyc("t3k0", 1, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t3k1", 1, 0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t3k2", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    cyc("t3k3", 1, 0, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    cyc("t3k4", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);
    cyc("t3k5", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    cyc("t3k6", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    cyc("t3k7", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    cyc("t3clr", 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch3 rises 6 clk apart: both accepted
    cyc("t4a0", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4a1", 1, 0, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4a2", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4a3", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4a4", 1, 0, 4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4a5", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    cyc("t4a6", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    cyc("t4a7", 1, 0, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4a8", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4a9", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4aa", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4ab", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    cyc("t4ac", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    cyc("t4ad", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch3 rises 5 clk apart: second lands in last holdoff cycle
    cyc("t4b0", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4b1", 1, 0, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4b2", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4c0", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4c1", 1, 0, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t4c2", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4c3", 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4c4", 1, 0, 4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
    cyc("t4c5", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    cyc("t4c6", 1, 0, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    cyc("t4c7", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    cyc("t4c8", 1, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    cyc("t4clr", 1, 1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Enable low: edges on every channel, no pulses, no overruns
    cyc("t5a0", 0, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t5a1", 0, 0, 4'b0110, 4'b0110, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    cyc("t5a2", 0, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t5a3", 0, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t5a4", 0, 0, 4'b1001, 4'b1001, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    cyc("t5a5", 0, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Enable dropped after the trigger is taken: pulse still runs to completion
    cyc("t5b0", 1, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t5b1", 1, 0, 4'b1011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t5b2", 1, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    cyc("t5b3", 0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    cyc("t5b4", 0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    cyc("t5b5", 0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    cyc("t5b6", 0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    cyc("t5b7", 0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Clear coincident with an overrun: set wins
    cyc("t6k0", 1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t6k1", 1, 0, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc("t6k2", 1, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    cyc("t6k3", 1, 0, 4'b1011, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    cyc("t6k4", 1, 1, 4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);
    cyc("t6k5", 1, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    cyc("t6k6", 1, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    cyc("t6k7", 1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    cyc("t6k8", 1, 0, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    cyc("t6k9", 1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);

    // Async reset mid-pulse, checked before any further clock edge
    resetn_i = 1'b0;
    #1;
    check("arst/up",   pulse_up, 4'b0000);
    check("arst/dn",   pulse_dn, 4'b0000);
    check("arst/po",   pulse_o,  4'b0000);
    check("arst/busy", busy_o,   4'b0000);
    check("arst/ovr",  ovr_o,    4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
